core_mem_s: RTL and testbench

CORE_MEM_S -- requirements
Module: core_mem_s

---
 rtl/core_mem_s.sv | 165 ++++++++++++++++
 tb/tb_core_mem_s.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_mem_s.sv
// core_mem_s: memory stage that issues L1D requests, aligns and extends load data and registers the writeback.
// Define CORE_MEM_MISALIGN_CHK_EN to suppress misaligned half/word accesses and flag them on mem_misalign_out_reg.
module core_mem_s (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_enb,
   input  logic        mem_kill,
   input  logic [31:0] mem_alu_result_in,
   input  logic [31:0] mem_addr_in,
   input  logic [31:0] mem_w_data_in,
   input  logic [6:0]  mem_l1d_bus_in,
   input  logic        mem_mux_alu_mem_in,
   input  logic        mem_we_reg_file_in,
   input  logic [2:0]  mem_wb_sx_op_in,
   input  logic [4:0]  mem_rd_in,
   output logic        l1d_req_val,
   output logic        l1d_req_cop,
   output logic [31:0] l1d_req_addr,
   output logic [31:0] l1d_req_wdata,
   output logic [3:0]  l1d_req_be,
   input  logic        l1d_req_ack,
   input  logic        l1d_resp_val,
   input  logic [31:0] l1d_resp_rdata,
   output logic [31:0] mem_result_out_reg,
   output logic        mem_we_reg_file_out_reg,
   output logic [4:0]  mem_rd_out_reg,
`ifdef CORE_MEM_MISALIGN_CHK_EN
   output logic        mem_misalign_out_reg,
`endif
   output logic [31:0] mem2exe_result,
   output logic        mem2haz_stall
);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RESP, DRAIN} state_t;

   state_t      state, state_nxt;
   logic        op_vld, is_wr, misalign, mem_op;
   logic [1:0]  size;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext, result_nxt;
   logic [2:0]  unused_bus;

   assign unused_bus = mem_l1d_bus_in[6:4];

   assign op_vld = mem_l1d_bus_in[0] & ~mem_kill;
   assign is_wr  = mem_l1d_bus_in[1];
   assign size   = mem_l1d_bus_in[3:2];

`ifdef CORE_MEM_MISALIGN_CHK_EN
   assign misalign = ((size == 2'b01) & mem_addr_in[0]) | (size[1] & (mem_addr_in[1:0] != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   // A misaligned op never reaches the cache, so it neither requests nor stalls.
   assign mem_op = op_vld & ~misalign;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, WAIT_ACK: begin
            if (!mem_op)          state_nxt = IDLE;
            else if (l1d_req_ack) state_nxt = is_wr ? IDLE : WAIT_RESP;
            else                  state_nxt = WAIT_ACK;
         end
         // A response arriving with the kill completes the old load, so there is nothing left to drain.
         WAIT_RESP: begin
            if (l1d_resp_val)  state_nxt = IDLE;
            else if (mem_kill) state_nxt = DRAIN;
         end
         DRAIN: begin
            if (l1d_resp_val) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      l1d_req_val   = 1'b0;
      mem2haz_stall = 1'b0;
      if (!rst) begin
         case (state)
            IDLE, WAIT_ACK: begin
               l1d_req_val   = mem_op;
               mem2haz_stall = mem_op & ~(is_wr & l1d_req_ack);
            end
            WAIT_RESP: mem2haz_stall = op_vld & ~l1d_resp_val;
            DRAIN:     mem2haz_stall = op_vld;
            default: begin
               l1d_req_val   = 1'b0;
               mem2haz_stall = 1'b0;
            end
         endcase
      end
   end

   assign l1d_req_cop    = is_wr;
   assign l1d_req_addr   = {mem_addr_in[31:2], 2'b00};
   assign mem2exe_result = mem_alu_result_in;

   always_comb begin
      l1d_req_be    = 4'b1111;
      l1d_req_wdata = mem_w_data_in;
      case (size)
         2'b00: begin
            l1d_req_be    = 4'b0001 << mem_addr_in[1:0];
            l1d_req_wdata = {4{mem_w_data_in[7:0]}};
         end
         2'b01: begin
            l1d_req_be    = 4'b0011 << {mem_addr_in[1], 1'b0};
            l1d_req_wdata = {2{mem_w_data_in[15:0]}};
         end
         default: begin
            l1d_req_be    = 4'b1111;
            l1d_req_wdata = mem_w_data_in;
         end
      endcase
   end

   always_comb begin
      case (mem_addr_in[1:0])
         2'b00:   ld_byte = l1d_resp_rdata[7:0];
         2'b01:   ld_byte = l1d_resp_rdata[15:8];
         2'b10:   ld_byte = l1d_resp_rdata[23:16];
         default: ld_byte = l1d_resp_rdata[31:24];
      endcase
      ld_half = mem_addr_in[1] ? l1d_resp_rdata[31:16] : l1d_resp_rdata[15:0];
      case (mem_wb_sx_op_in)
         3'b001:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         3'b010:  ld_ext = {24'd0, ld_byte};
         3'b011:  ld_ext = {{16{ld_half[15]}}, ld_half};
         3'b100:  ld_ext = {16'd0, ld_half};
         default: ld_ext = l1d_resp_rdata;
      endcase
   end

   assign result_nxt = mem_mux_alu_mem_in ? ld_ext : mem_alu_result_in;

   // Kill flushes the writeback slot even while the stage is stalled or disabled.
   always_ff @(posedge clk) begin
      if (rst || mem_kill) begin
         mem_result_out_reg      <= 32'd0;
         mem_we_reg_file_out_reg <= 1'b0;
         mem_rd_out_reg          <= 5'd0;
      end else if (mem_enb && !mem2haz_stall) begin
         mem_result_out_reg      <= result_nxt;
         mem_we_reg_file_out_reg <= mem_we_reg_file_in & ~(op_vld & misalign);
         mem_rd_out_reg          <= mem_rd_in;
      end
   end

`ifdef CORE_MEM_MISALIGN_CHK_EN
   always_ff @(posedge clk) begin
      if (rst || mem_kill)                mem_misalign_out_reg <= 1'b0;
      else if (mem_enb && !mem2haz_stall) mem_misalign_out_reg <= op_vld & misalign;
   end
`endif

endmodule

// File: tb/tb_core_mem_s.sv
// Directed bench for core_mem_s: store/load encodings, stall timing, kill/drain, reset and optional misalign checks.
module tb_core_mem_s;

   logic        clk = 1'b0;
   logic        rst;
   logic        mem_enb, mem_kill;
   logic [31:0] mem_alu_result_in, mem_addr_in, mem_w_data_in;
   logic [6:0]  mem_l1d_bus_in;
   logic        mem_mux_alu_mem_in, mem_we_reg_file_in;
   logic [2:0]  mem_wb_sx_op_in;
   logic [4:0]  mem_rd_in;
   logic        l1d_req_val, l1d_req_cop;
   logic [31:0] l1d_req_addr, l1d_req_wdata;
   logic [3:0]  l1d_req_be;
   logic        l1d_req_ack, l1d_resp_val;
   logic [31:0] l1d_resp_rdata;
   logic [31:0] mem_result_out_reg, mem2exe_result;
   logic        mem_we_reg_file_out_reg, mem2haz_stall;
   logic [4:0]  mem_rd_out_reg;
`ifdef CORE_MEM_MISALIGN_CHK_EN
   logic        mem_misalign_out_reg;
`endif

   int n_vec = 0;
   int n_err = 0;

   localparam logic [6:0] OP_LB = 7'h01, OP_LH = 7'h05, OP_LW = 7'h09;
   localparam logic [6:0] OP_SB = 7'h03, OP_SH = 7'h07, OP_SW = 7'h0B;

   always #5 clk = ~clk;

   core_mem_s dut (
      .clk(clk), .rst(rst), .mem_enb(mem_enb), .mem_kill(mem_kill),
      .mem_alu_result_in(mem_alu_result_in), .mem_addr_in(mem_addr_in),
      .mem_w_data_in(mem_w_data_in), .mem_l1d_bus_in(mem_l1d_bus_in),
      .mem_mux_alu_mem_in(mem_mux_alu_mem_in), .mem_we_reg_file_in(mem_we_reg_file_in),
      .mem_wb_sx_op_in(mem_wb_sx_op_in), .mem_rd_in(mem_rd_in),
      .l1d_req_val(l1d_req_val), .l1d_req_cop(l1d_req_cop), .l1d_req_addr(l1d_req_addr),
      .l1d_req_wdata(l1d_req_wdata), .l1d_req_be(l1d_req_be), .l1d_req_ack(l1d_req_ack),
      .l1d_resp_val(l1d_resp_val), .l1d_resp_rdata(l1d_resp_rdata),
      .mem_result_out_reg(mem_result_out_reg), .mem_we_reg_file_out_reg(mem_we_reg_file_out_reg),
      .mem_rd_out_reg(mem_rd_out_reg),
`ifdef CORE_MEM_MISALIGN_CHK_EN
      .mem_misalign_out_reg(mem_misalign_out_reg),
`endif
      .mem2exe_result(mem2exe_result), .mem2haz_stall(mem2haz_stall)
   );

   task automatic drive_nop();
      rst = 1'b0; mem_enb = 1'b1; mem_kill = 1'b0;
      mem_alu_result_in = 32'd0; mem_addr_in = 32'd0; mem_w_data_in = 32'd0;
      mem_l1d_bus_in = 7'd0; mem_mux_alu_mem_in = 1'b0; mem_we_reg_file_in = 1'b0;
      mem_wb_sx_op_in = 3'd0; mem_rd_in = 5'd0;
      l1d_req_ack = 1'b0; l1d_resp_val = 1'b0; l1d_resp_rdata = 32'd0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      drive_nop();
      rst = 1'b1;
      mem_l1d_bus_in = OP_LW;
      mem_we_reg_file_in = 1'b1;
      mem_alu_result_in = 32'h1234_5678;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL reset_comb req_val=%b stall=%b want 0/0", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'd0 || mem_we_reg_file_out_reg !== 1'b0 || mem_rd_out_reg !== 5'd0) begin
         n_err++; $display("FAIL reset_regs result=%h we=%b rd=%0d want 0/0/0",
                           mem_result_out_reg, mem_we_reg_file_out_reg, mem_rd_out_reg);
      end
`ifdef CORE_MEM_MISALIGN_CHK_EN
      n_vec++;
      if (mem_misalign_out_reg !== 1'b0) begin
         n_err++; $display("FAIL reset_misalign got=%b want 0", mem_misalign_out_reg);
      end
`endif
      drive_nop();
   endtask

   task automatic test_alu_enable_kill();
      drive_nop();
      mem_alu_result_in = 32'h0000_0055; mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd3;
      @(negedge clk);
      n_vec++;
      if (mem2exe_result !== 32'h55 || l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL alu_comb bypass=%h req_val=%b stall=%b want 55/0/0",
                           mem2exe_result, l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'h55 || mem_we_reg_file_out_reg !== 1'b1 || mem_rd_out_reg !== 5'd3) begin
         n_err++; $display("FAIL alu_wb result=%h we=%b rd=%0d want 55/1/3",
                           mem_result_out_reg, mem_we_reg_file_out_reg, mem_rd_out_reg);
      end
      mem_enb = 1'b0; mem_alu_result_in = 32'h66; mem_rd_in = 5'd4;
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'h55 || mem_rd_out_reg !== 5'd3) begin
         n_err++; $display("FAIL enb_hold result=%h rd=%0d want 55/3", mem_result_out_reg, mem_rd_out_reg);
      end
      mem_enb = 1'b1; mem_kill = 1'b1;
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'd0 || mem_we_reg_file_out_reg !== 1'b0 || mem_rd_out_reg !== 5'd0) begin
         n_err++; $display("FAIL kill_flush result=%h we=%b rd=%0d want 0/0/0",
                           mem_result_out_reg, mem_we_reg_file_out_reg, mem_rd_out_reg);
      end
      drive_nop();
      mem_alu_result_in = 32'h77; mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd2;
      l1d_resp_val = 1'b1; l1d_resp_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      n_vec++;
      if (mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL resp_in_idle stall=%b want 0", mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'h77) begin
         n_err++; $display("FAIL resp_in_idle_wb result=%h want 77", mem_result_out_reg);
      end
      drive_nop();
   endtask

   task automatic test_store_word();
      drive_nop();
      mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd1; mem_alu_result_in = 32'h1;
      next_cycle();
      mem_l1d_bus_in = OP_SW; mem_addr_in = 32'h100; mem_w_data_in = 32'hDEAD_BEEF;
      mem_alu_result_in = 32'h100; mem_we_reg_file_in = 1'b0; mem_rd_in = 5'd0; l1d_req_ack = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b1 || l1d_req_cop !== 1'b1 || l1d_req_addr !== 32'h100 ||
          l1d_req_be !== 4'b1111 || l1d_req_wdata !== 32'hDEAD_BEEF || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL sw_req val=%b cop=%b addr=%h be=%b wdata=%h stall=%b want 1/1/100/1111/deadbeef/0",
                           l1d_req_val, l1d_req_cop, l1d_req_addr, l1d_req_be, l1d_req_wdata, mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_we_reg_file_out_reg !== 1'b0) begin
         n_err++; $display("FAIL sw_no_wb we=%b want 0", mem_we_reg_file_out_reg);
      end
      drive_nop();
   endtask

   task automatic test_store_sub_word();
      drive_nop();
      mem_l1d_bus_in = OP_SH; mem_addr_in = 32'h102; mem_w_data_in = 32'hABCD_1234; l1d_req_ack = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_be !== 4'b1100 || l1d_req_wdata !== 32'h1234_1234 || l1d_req_addr !== 32'h100 ||
          mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL sh_req be=%b wdata=%h addr=%h stall=%b want 1100/12341234/100/0",
                           l1d_req_be, l1d_req_wdata, l1d_req_addr, mem2haz_stall);
      end
      next_cycle();
      mem_l1d_bus_in = OP_SB; mem_addr_in = 32'h101; mem_w_data_in = 32'h0000_775A; l1d_req_ack = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_be !== 4'b0010 || l1d_req_wdata !== 32'h5A5A_5A5A) begin
         n_err++; $display("FAIL sb_req be=%b wdata=%h want 0010/5a5a5a5a", l1d_req_be, l1d_req_wdata);
      end
      next_cycle();
      drive_nop();
   endtask

   task automatic test_load_byte();
      int stalls;
      stalls = 0;
      drive_nop();
      mem_l1d_bus_in = OP_LB; mem_addr_in = 32'h103; mem_wb_sx_op_in = 3'b001;
      mem_mux_alu_mem_in = 1'b1; mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd5; l1d_req_ack = 1'b1;
      @(negedge clk);
      if (mem2haz_stall) stalls++;
      n_vec++;
      if (l1d_req_val !== 1'b1 || l1d_req_cop !== 1'b0 || l1d_req_addr !== 32'h100 || l1d_req_be !== 4'b1000) begin
         n_err++; $display("FAIL lb_req val=%b cop=%b addr=%h be=%b want 1/0/100/1000",
                           l1d_req_val, l1d_req_cop, l1d_req_addr, l1d_req_be);
      end
      next_cycle();
      l1d_req_ack = 1'b0;
      @(negedge clk);
      if (mem2haz_stall) stalls++;
      n_vec++;
      if (l1d_req_val !== 1'b0) begin
         n_err++; $display("FAIL lb_wait_resp req_val=%b want 0", l1d_req_val);
      end
      next_cycle();
      l1d_resp_val = 1'b1; l1d_resp_rdata = 32'h80FF_FF00;
      @(negedge clk);
      if (mem2haz_stall) stalls++;
      next_cycle();
      n_vec++;
      if (stalls != 2) begin
         n_err++; $display("FAIL lb_stall_cycles got=%0d want 2", stalls);
      end
      n_vec++;
      if (mem_result_out_reg !== 32'hFFFF_FF80 || mem_we_reg_file_out_reg !== 1'b1 || mem_rd_out_reg !== 5'd5) begin
         n_err++; $display("FAIL lb_result result=%h we=%b rd=%0d want ffffff80/1/5",
                           mem_result_out_reg, mem_we_reg_file_out_reg, mem_rd_out_reg);
      end
      drive_nop();
   endtask

   task automatic test_load_ext();
      logic [6:0]  t_op  [6] = '{OP_LB, OP_LB, OP_LH, OP_LH, OP_LW, OP_LW};
      logic [31:0] t_adr [6] = '{32'h201, 32'h200, 32'h202, 32'h200, 32'h204, 32'h208};
      logic [2:0]  t_sx  [6] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b000, 3'b111};
      logic [31:0] t_exp [6] = '{32'h0000_00C3, 32'hFFFF_FFA1, 32'hFFFF_8765,
                                 32'h0000_C3A1, 32'h8765_C3A1, 32'h8765_C3A1};
      for (int i = 0; i < 6; i++) begin
         int stalls;
         stalls = 0;
         drive_nop();
         mem_l1d_bus_in = t_op[i]; mem_addr_in = t_adr[i]; mem_wb_sx_op_in = t_sx[i];
         mem_mux_alu_mem_in = 1'b1; mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd6; l1d_req_ack = 1'b1;
         @(negedge clk);
         if (mem2haz_stall) stalls++;
         next_cycle();
         l1d_req_ack = 1'b0; l1d_resp_val = 1'b1; l1d_resp_rdata = 32'h8765_C3A1;
         @(negedge clk);
         if (mem2haz_stall) stalls++;
         next_cycle();
         n_vec++;
         if (mem_result_out_reg !== t_exp[i] || stalls != 1) begin
            n_err++; $display("FAIL load_ext[%0d] result=%h stalls=%0d want %h/1",
                              i, mem_result_out_reg, stalls, t_exp[i]);
         end
      end
      drive_nop();
   endtask

   task automatic test_ack_wait();
      drive_nop();
      mem_l1d_bus_in = OP_SW; mem_addr_in = 32'h2F4; mem_w_data_in = 32'h1111_2222;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         n_vec++;
         if (l1d_req_val !== 1'b1 || l1d_req_addr !== 32'h2F4 || l1d_req_wdata !== 32'h1111_2222 ||
             mem2haz_stall !== 1'b1) begin
            n_err++; $display("FAIL ack_wait[%0d] val=%b addr=%h wdata=%h stall=%b want 1/2f4/11112222/1",
                              c, l1d_req_val, l1d_req_addr, l1d_req_wdata, mem2haz_stall);
         end
         next_cycle();
      end
      l1d_req_ack = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b1 || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL ack_wait_done val=%b stall=%b want 1/0", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      drive_nop();
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL ack_wait_idle val=%b stall=%b want 0/0", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
   endtask

   task automatic test_kill_drain();
      drive_nop();
      mem_l1d_bus_in = OP_LW; mem_addr_in = 32'h300; mem_mux_alu_mem_in = 1'b1;
      mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd9; l1d_req_ack = 1'b1;
      next_cycle();
      l1d_req_ack = 1'b0; mem_kill = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL kill_wait_resp val=%b stall=%b want 0/0", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'd0 || mem_we_reg_file_out_reg !== 1'b0) begin
         n_err++; $display("FAIL kill_regs result=%h we=%b want 0/0", mem_result_out_reg, mem_we_reg_file_out_reg);
      end
      mem_kill = 1'b0; mem_addr_in = 32'h304; mem_rd_in = 5'd10;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b1) begin
         n_err++; $display("FAIL drain_hold val=%b stall=%b want 0/1", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      l1d_resp_val = 1'b1; l1d_resp_rdata = 32'hBAD0_BAD0;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b1) begin
         n_err++; $display("FAIL drain_resp val=%b stall=%b want 0/1", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'd0 || mem_we_reg_file_out_reg !== 1'b0) begin
         n_err++; $display("FAIL drain_drop result=%h we=%b want 0/0", mem_result_out_reg, mem_we_reg_file_out_reg);
      end
      l1d_resp_val = 1'b0; l1d_resp_rdata = 32'd0; l1d_req_ack = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b1 || l1d_req_addr !== 32'h304 || mem2haz_stall !== 1'b1) begin
         n_err++; $display("FAIL drain_reissue val=%b addr=%h stall=%b want 1/304/1",
                           l1d_req_val, l1d_req_addr, mem2haz_stall);
      end
      next_cycle();
      l1d_req_ack = 1'b0; l1d_resp_val = 1'b1; l1d_resp_rdata = 32'h600D_F00D;
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'h600D_F00D || mem_rd_out_reg !== 5'd10 || mem_we_reg_file_out_reg !== 1'b1) begin
         n_err++; $display("FAIL drain_new_result result=%h rd=%0d we=%b want 600df00d/10/1",
                           mem_result_out_reg, mem_rd_out_reg, mem_we_reg_file_out_reg);
      end
      drive_nop();
   endtask

   task automatic test_reset_mid_load();
      drive_nop();
      mem_l1d_bus_in = OP_LW; mem_addr_in = 32'h400; mem_mux_alu_mem_in = 1'b1;
      mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd12; l1d_req_ack = 1'b1;
      next_cycle();
      l1d_req_ack = 1'b0; rst = 1'b1;
      next_cycle();
      rst = 1'b0; mem_addr_in = 32'h404;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b1 || l1d_req_addr !== 32'h404 || mem2haz_stall !== 1'b1) begin
         n_err++; $display("FAIL rst_no_drain val=%b addr=%h stall=%b want 1/404/1",
                           l1d_req_val, l1d_req_addr, mem2haz_stall);
      end
      l1d_req_ack = 1'b1;
      next_cycle();
      l1d_req_ack = 1'b0; l1d_resp_val = 1'b1; l1d_resp_rdata = 32'hCAFE_0404;
      next_cycle();
      n_vec++;
      if (mem_result_out_reg !== 32'hCAFE_0404 || mem_rd_out_reg !== 5'd12) begin
         n_err++; $display("FAIL rst_reload result=%h rd=%0d want cafe0404/12", mem_result_out_reg, mem_rd_out_reg);
      end
      drive_nop();
   endtask

   task automatic test_misalign();
      drive_nop();
      mem_l1d_bus_in = OP_LW; mem_addr_in = 32'h102; mem_mux_alu_mem_in = 1'b1;
      mem_we_reg_file_in = 1'b1; mem_rd_in = 5'd7;
`ifdef CORE_MEM_MISALIGN_CHK_EN
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b0 || mem2haz_stall !== 1'b0) begin
         n_err++; $display("FAIL misalign_req val=%b stall=%b want 0/0", l1d_req_val, mem2haz_stall);
      end
      next_cycle();
      n_vec++;
      if (mem_misalign_out_reg !== 1'b1 || mem_we_reg_file_out_reg !== 1'b0) begin
         n_err++; $display("FAIL misalign_flag flag=%b we=%b want 1/0", mem_misalign_out_reg, mem_we_reg_file_out_reg);
      end
      drive_nop();
      mem_we_reg_file_in = 1'b1;
      next_cycle();
      n_vec++;
      if (mem_misalign_out_reg !== 1'b0 || mem_we_reg_file_out_reg !== 1'b1) begin
         n_err++; $display("FAIL misalign_clear flag=%b we=%b want 0/1", mem_misalign_out_reg, mem_we_reg_file_out_reg);
      end
`else
      l1d_req_ack = 1'b1;
      @(negedge clk);
      n_vec++;
      if (l1d_req_val !== 1'b1 || l1d_req_addr !== 32'h100 || l1d_req_be !== 4'b1111) begin
         n_err++; $display("FAIL misalign_issue val=%b addr=%h be=%b want 1/100/1111",
                           l1d_req_val, l1d_req_addr, l1d_req_be);
      end
      next_cycle();
      l1d_req_ack = 1'b0; l1d_resp_val = 1'b1; l1d_resp_rdata = 32'h0102_0304;
      next_cycle();
`endif
      drive_nop();
      next_cycle();
   endtask

   initial begin
      drive_nop();
      next_cycle();
      test_reset();
      test_alu_enable_kill();
      test_store_word();
      test_store_sub_word();
      test_load_byte();
      test_load_ext();
      test_ack_wait();
      test_kill_drain();
      test_reset_mid_load();
      test_misalign();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
